// File: rtl/hazard3_timer_pkg.sv
// hazard3_timer_pkg: register map shared by hazard3_riscv_timer and hazard3_timer_tickgen
// Holds byte offsets and bit positions for both blocks on the peripheral APB segment.
package hazard3_timer_pkg;
    localparam logic [7:0] TIMER_CTRL       = 8'h00;
    localparam logic [7:0] TIMER_MTIME      = 8'h08;
    localparam logic [7:0] TIMER_MTIMEH     = 8'h0c;
    localparam logic [7:0] TIMER_MTIMECMP   = 8'h10;
    localparam logic [7:0] TIMER_MTIMECMPH  = 8'h14;
    localparam logic [7:0] TICKGEN_CTRL     = 8'h00;
    localparam logic [7:0] TICKGEN_DIV_INT  = 8'h04;
    localparam logic [7:0] TICKGEN_DIV_FRAC = 8'h08;
    localparam logic [7:0] TICKGEN_STATUS   = 8'h0c;
    localparam int TICKGEN_CTRL_EN        = 0;
    localparam int TICKGEN_STATUS_NRZ     = 0;
    localparam int TICKGEN_STATUS_CTR_LSB = 16;
endpackage

// File: rtl/hazard3_tickgen_ctr.sv
// hazard3_tickgen_ctr: reload down-counter with fractional accumulator for the tick generator
// Ports: clk, rst_n (async active-low); i_en run enable; i_start restart from a fresh period;
//        i_div_int / i_div_frac divisor; o_expire high on the cycle the period ends; o_ctr live count.
// Macro HAZARD3_TICKGEN_FRAC_EN: when undefined the accumulator is absent and carry is 0.
module hazard3_tickgen_ctr
    import hazard3_timer_pkg::*;
#(
    parameter int W_DIV  = 16,
    parameter int W_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_start,
    input  logic [W_DIV-1:0]  i_div_int,
    input  logic [W_FRAC-1:0] i_div_frac,
    output logic              o_expire,
    output logic [W_DIV-1:0]  o_ctr
);
    logic [W_DIV-1:0] r_ctr;
    logic [W_DIV-1:0] w_div_m1;
    logic             w_carry;

    // divisor 0 behaves as 1
    assign w_div_m1 = (i_div_int == '0) ? '0 : i_div_int - 1'b1;
    assign o_expire = i_en && (r_ctr == '0);
    assign o_ctr    = r_ctr;

`ifdef HAZARD3_TICKGEN_FRAC_EN
    logic [W_FRAC-1:0] r_acc;
    logic [W_FRAC:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_div_frac};
    assign w_carry = w_sum[W_FRAC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_start)
            r_acc <= '0;
        else if (o_expire)
            r_acc <= w_sum[W_FRAC-1:0];
    end
`else
    logic w_unused;

    assign w_unused = ^i_div_frac;
    assign w_carry  = 1'b0;
`endif

    // a carry stretches the next period by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ctr <= '0;
        else if (i_start)
            r_ctr <= w_div_m1;
        else if (o_expire)
            r_ctr <= w_div_m1 + W_DIV'(w_carry);
        else if (i_en)
            r_ctr <= r_ctr - 1'b1;
    end
endmodule

// File: rtl/hazard3_timer_tickgen.sv
// hazard3_timer_tickgen: APB-programmable integer+fraction clock divider producing tick_nrz for hazard3_riscv_timer
// Ports: clk, rst_n (async active-low); APB slave i_psel/i_penable/i_pwrite/i_paddr/i_pwdata,
//        o_prdata (combinational from i_paddr), o_pready=1, o_pslverr=0;
//        o_tick_nrz toggles once per divider period, o_tick_pulse marks each toggle.
// Macro HAZARD3_TICKGEN_FRAC_EN enables DIV_FRAC storage and the fractional accumulator.
module hazard3_timer_tickgen
    import hazard3_timer_pkg::*;
#(
    parameter int W_DIV  = 16,
    parameter int W_FRAC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_psel,
    input  logic        i_penable,
    input  logic        i_pwrite,
    input  logic [7:0]  i_paddr,
    input  logic [31:0] i_pwdata,
    output logic [31:0] o_prdata,
    output logic        o_pready,
    output logic        o_pslverr,
    output logic        o_tick_nrz,
    output logic        o_tick_pulse
);
    logic              w_wr;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_run;
    logic              w_expire;
    logic [W_DIV-1:0]  w_ctr;
    logic [W_FRAC-1:0] w_div_frac;
    logic [31:0]       w_status;
    logic              w_unused;
    logic              r_en;
    logic              r_tick_nrz;
    logic              r_tick_pulse;
    logic [W_DIV-1:0]  r_div_int;

    assign w_wr      = i_psel && i_penable && i_pwrite;
    assign w_ctrl_wr = w_wr && (i_paddr == TICKGEN_CTRL);
    // only a 0->1 transition restarts; rewriting EN=1 while running is a no-op
    assign w_start   = w_ctrl_wr && i_pwdata[TICKGEN_CTRL_EN] && !r_en;
    // an EN=0 write freezes the counter on that same edge, suppressing a coincident toggle
    assign w_run     = r_en && !(w_ctrl_wr && !i_pwdata[TICKGEN_CTRL_EN]);
    assign w_unused  = ^i_pwdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en         <= 1'b0;
            r_div_int    <= W_DIV'(1);
            r_tick_nrz   <= 1'b0;
            r_tick_pulse <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_en <= i_pwdata[TICKGEN_CTRL_EN];
            if (w_wr && (i_paddr == TICKGEN_DIV_INT))
                r_div_int <= i_pwdata[W_DIV-1:0];
            r_tick_nrz   <= r_tick_nrz ^ w_expire;
            r_tick_pulse <= w_expire;
        end
    end

`ifdef HAZARD3_TICKGEN_FRAC_EN
    logic [W_FRAC-1:0] r_div_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div_frac <= '0;
        else if (w_wr && (i_paddr == TICKGEN_DIV_FRAC))
            r_div_frac <= i_pwdata[W_FRAC-1:0];
    end

    assign w_div_frac = r_div_frac;
`else
    assign w_div_frac = '0;
`endif

    // reload samples the divisor registers before any same-edge write lands
    hazard3_tickgen_ctr #(
        .W_DIV  (W_DIV),
        .W_FRAC (W_FRAC)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_run),
        .i_start    (w_start),
        .i_div_int  (r_div_int),
        .i_div_frac (w_div_frac),
        .o_expire   (w_expire),
        .o_ctr      (w_ctr)
    );

    assign w_status = (32'(w_ctr) << TICKGEN_STATUS_CTR_LSB) | (32'(r_tick_nrz) << TICKGEN_STATUS_NRZ);

    assign o_prdata = (i_paddr == TICKGEN_CTRL)     ? 32'(r_en)       :
                      (i_paddr == TICKGEN_DIV_INT)  ? 32'(r_div_int)  :
                      (i_paddr == TICKGEN_DIV_FRAC) ? 32'(w_div_frac) :
                      (i_paddr == TICKGEN_STATUS)   ? w_status        : 32'h0;

    assign o_pready     = 1'b1;
    assign o_pslverr    = 1'b0;
    assign o_tick_nrz   = r_tick_nrz;
    assign o_tick_pulse = r_tick_pulse;
endmodule
